// File: rtl/regfile.sv
// RV64I integer register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero, and write-to-read bypass on both ports.
module regfile #(
  parameter int XLEN   = 64,
  parameter int REGNUM = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  localparam logic [5:0] LP_REGNUM = 6'(REGNUM);

  // x0 has no storage; only x1..x(REGNUM-1) are kept
  logic [XLEN-1:0] r_regs [REGNUM-1:1];

  logic            w_waddr_ok;
  logic            w_wr_en;
  logic            w_raddr1_ok;
  logic            w_raddr2_ok;
  logic            w_byp1;
  logic            w_byp2;
  logic [XLEN-1:0] w_stored1;
  logic [XLEN-1:0] w_stored2;

  assign w_waddr_ok  = (waddr  != 5'd0) && ({1'b0, waddr}  < LP_REGNUM);
  assign w_raddr1_ok = (raddr1 != 5'd0) && ({1'b0, raddr1} < LP_REGNUM);
  assign w_raddr2_ok = (raddr2 != 5'd0) && ({1'b0, raddr2} < LP_REGNUM);
  assign w_wr_en     = !rst && we && w_waddr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < REGNUM; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      for (int i = 1; i < REGNUM; i++) begin
        if (waddr == 5'(i)) begin
          r_regs[i] <= wdata;
        end
      end
    end
  end

  // Mux-by-compare keeps out-of-range indices from ever touching the array
  always_comb begin
    w_stored1 = '0;
    w_stored2 = '0;
    for (int i = 1; i < REGNUM; i++) begin
      if (raddr1 == 5'(i)) w_stored1 = r_regs[i];
      if (raddr2 == 5'(i)) w_stored2 = r_regs[i];
    end
  end

  // w_wr_en already excludes reset, x0 and out-of-range targets
  assign w_byp1 = w_wr_en && (waddr == raddr1);
  assign w_byp2 = w_wr_en && (waddr == raddr2);

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (w_raddr1_ok) rdata1 = w_byp1 ? wdata : w_stored1;
    if (w_raddr2_ok) rdata2 = w_byp2 ? wdata : w_stored2;
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed plan plus randomized traffic
// compared against an array-based reference model.
module tb_regfile;

  localparam int XLEN   = 64;
  localparam int REGNUM = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            we;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;
  logic [4:0]      raddr1;
  logic [4:0]      raddr2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;

  int n_vec = 0;
  int n_err = 0;

  logic [XLEN-1:0] m_regs [32];

  regfile #(.XLEN(XLEN), .REGNUM(REGNUM)) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model_read(input int a);
    if (a == 0 || a >= REGNUM) return '0;
    if (!rst && we && int'(waddr) == a) return wdata;
    return m_regs[a];
  endfunction

  // Advance one edge, update the model from the inputs seen at that edge
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else if (we && waddr != 0 && int'(waddr) < REGNUM) begin
      m_regs[waddr] = wdata;
    end
    #1;
  endtask

  task automatic check_reads(input string tag);
    #1;
    chk({tag, "_rd1"}, rdata1, model_read(int'(raddr1)));
    chk({tag, "_rd2"}, rdata2, model_read(int'(raddr2)));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 64'(i * 'h10);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(i);
      #1;
      chk("fill_rd1", rdata1, 64'(i * 'h10));
      chk("fill_rd2", rdata2, 64'(i * 'h10));
    end
    raddr1 = 5'd31; #1;
    chk("fill_x31", rdata1, 64'h1F0);

    we = 1'b1; waddr = 5'd0; wdata = 64'hDEADBEEFDEADBEEF; raddr1 = 5'd0;
    #1; chk("x0_byp", rdata1, '0);
    tick();
    we = 1'b0; #1;
    chk("x0_prot", rdata1, '0);

    we = 1'b1; waddr = 5'd5; wdata = 64'hCAFEBABECAFEBABE;
    raddr1 = 5'd5; raddr2 = 5'd0;
    #1;
    chk("byp_rd1", rdata1, 64'hCAFEBABECAFEBABE);
    chk("byp_rd2", rdata2, '0);
    tick();
    we = 1'b0; #1;
    chk("raw_rd1", rdata1, 64'hCAFEBABECAFEBABE);

    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      chk("clr_rd1", rdata1, '0);
      chk("clr_rd2", rdata2, '0);
    end

    we = 1'b1; waddr = 5'd7; wdata = 64'h1234; tick();
    rst = 1'b1; raddr1 = 5'd7; #1;
    chk("rstpri_during", rdata1, 64'h1234);
    wdata = 64'h5678; #1;
    chk("rstpri_nobyp", rdata1, 64'h1234);
    tick();
    rst = 1'b0; we = 1'b0; #1;
    chk("rstpri_after", rdata1, '0);

    we = 1'b1; waddr = 5'd3; wdata = 64'hAA; tick();
    waddr = 5'd4; wdata = 64'h55; tick();
    we = 1'b0; raddr1 = 5'd3; raddr2 = 5'd4; #1;
    chk("dual_rd1", rdata1, 64'hAA);
    chk("dual_rd2", rdata2, 64'h55);
    raddr1 = 5'd4; raddr2 = 5'd3; #1;
    chk("swap_rd1", rdata1, 64'h55);
    chk("swap_rd2", rdata2, 64'hAA);

    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 49) == 0);
      we     = $urandom_range(0, 3) != 0;
      waddr  = 5'($urandom_range(0, 31));
      wdata  = {$urandom, $urandom};
      raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      check_reads("rnd");
      tick();
    end

    rst = 1'b0; we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(i);
      check_reads("final");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
